uart_tx_buffered: RTL

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_tx_buffered.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - UART transmitter fed by a small byte FIFO
// Frames are 1 start bit, NB_DATA data bits LSB first, then a stop bit timed by SB_TICK.
module uart_tx_buffered #(
  parameter int NB_DATA = 8,
  parameter int SB_TICK = 16,
  parameter int NB_PTR  = 2
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               s_tick,
  input  logic               tx_start,
  input  logic [NB_DATA-1:0] din,
  output logic               tx,
  output logic               tx_done_tick,
  output logic               ready,
  output logic               busy,
  output logic               overflow
);

  localparam int              DEPTH     = 2 ** NB_PTR;
  localparam int              CW        = NB_PTR + 1;
  localparam logic [CW-1:0]   FULL      = CW'(DEPTH);
  localparam logic [3:0]      TICK_LAST = 4'd15;
  localparam logic [3:0]      STOP_LAST = 4'(SB_TICK - 1);
  localparam logic [2:0]      DATA_LAST = 3'(NB_DATA - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           s_cnt_q, s_cnt_d;
  logic [2:0]           n_cnt_q, n_cnt_d;
  logic [NB_DATA-1:0]   shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;

  logic [NB_DATA-1:0]   mem_q [DEPTH];
  logic [NB_PTR-1:0]    wr_ptr_q, wr_ptr_d;
  logic [NB_PTR-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  logic                 pop;
  logic                 push;
  logic                 drop;

  // A full FIFO still takes a write when the FSM drains the head in the same cycle.
  assign pop  = (state_q == IDLE) && (count_q != '0);
  assign push = tx_start && ((count_q != FULL) || pop);
  assign drop = tx_start && !push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | drop;
    if (push) begin
      wr_ptr_d = wr_ptr_q + NB_PTR'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + NB_PTR'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          s_cnt_d = 4'd0;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (s_tick) begin
          if (s_cnt_q == TICK_LAST) begin
            s_cnt_d = 4'd0;
            n_cnt_d = 3'd0;
            state_d = DATA;
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (s_tick) begin
          if (s_cnt_q == TICK_LAST) begin
            s_cnt_d = 4'd0;
            shift_d = shift_q >> 1;
            if (n_cnt_q == DATA_LAST) begin
              state_d = STOP;
            end else begin
              n_cnt_d = n_cnt_q + 3'd1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (s_cnt_q == STOP_LAST) begin
            s_cnt_d = 4'd0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= IDLE;
      s_cnt_q  <= 4'd0;
      n_cnt_q  <= 3'd0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      s_cnt_q  <= s_cnt_d;
      n_cnt_q  <= n_cnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign tx           = tx_q;
  assign tx_done_tick = done_q;
  assign overflow     = ovf_q;
  assign ready        = (count_q != FULL);
  assign busy         = (state_q != IDLE) || (count_q != '0);

endmodule
